// File: rtl/fuzz_seq_pkg.sv
// Shared types, constants and helpers for the fuzz stimulus sequencer.
// Holds the run-state encoding, the LCG defaults and the MISR feedback taps.
package fuzz_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        FILL,
        COMMIT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] LCG_A_DEF = 32'h41C64E6D;
    localparam logic [31:0] LCG_C_DEF = 32'h00003039;

    // Feedback taps at bits 31, 21, 1 and 0.
    localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lcg_next(input logic [31:0] s,
                                             input logic [31:0] a,
                                             input logic [31:0] c);
        return s * a + c;
    endfunction

    function automatic int nwords(input int w);
        return (w + 31) / 32;
    endfunction

endpackage

// File: rtl/sig_misr32.sv
// 32-bit MISR that XOR-folds a wide response into one word per absorb.
// clear reloads all-ones; en absorbs the current data word.
module sig_misr32
    import fuzz_seq_pkg::*;
#(
    parameter int OUT_W = 330
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [OUT_W-1:0] data,
    output logic [31:0]      sig
);
    localparam int NCH = nwords(OUT_W);

    logic [NCH*32-1:0] padded;
    logic [31:0]       fold;
    logic              fb;

    always_comb begin
        padded            = '0;
        padded[OUT_W-1:0] = data;
        fold              = '0;
        for (int i = 0; i < NCH; i++) begin
            fold = fold ^ padded[32*i +: 32];
        end
    end

    assign fb = ^(sig & MISR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 32'hFFFF_FFFF;
        end else if (clear) begin
            sig <= 32'hFFFF_FFFF;
        end else if (en) begin
            sig <= {sig[30:0], fb} ^ fold;
        end
    end

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// Run controller for a fuzzed DUT: sequences its reset, streams LCG vectors
// word by word into a shadow register and compresses responses into a MISR.
module fuzz_stim_sequencer
    import fuzz_seq_pkg::*;
#(
    parameter int          IN_W       = 265,
    parameter int          OUT_W      = 330,
    parameter int          RST_CYCLES = 2,
    parameter logic [31:0] LCG_A      = LCG_A_DEF,
    parameter logic [31:0] LCG_C      = LCG_C_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed,
    input  logic [31:0]      cycles,
    output logic             dut_rst_n,
    output logic [IN_W-1:0]  in_flat,
    input  logic [OUT_W-1:0] out_flat,
    output logic             busy,
    output logic             done,
    output logic [31:0]      vec_count,
    output logic [31:0]      signature,
    output state_t           dbg_state
);
    localparam int            NWORDS = nwords(IN_W);
    localparam int            KW     = $clog2(NWORDS + 1);
    localparam int            RW     = $clog2(RST_CYCLES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);

    state_t          state, state_nxt;
    logic [KW-1:0]   k;
    logic [RW-1:0]   rst_cnt;
    logic [31:0]     lcg_s, lcg_nxt, cycles_q;
    logic [IN_W-1:0] shadow;
    logic            start_ok, abort_ok, last_vec, misr_en;

    // start and abort are single-cycle pulses with no ready: start is taken
    // only in IDLE/DONE, abort only while busy, and abort wins when both fire.
    assign start_ok  = start && !abort && (state == IDLE || state == DONE);
    assign abort_ok  = abort && busy;
    assign busy      = state inside {RESET, FILL, COMMIT, DRAIN};
    assign done      = (state == DONE);
    assign dut_rst_n = state inside {FILL, COMMIT, DRAIN, DONE};
    assign dbg_state = state;
    assign lcg_nxt   = lcg_next(lcg_s, LCG_A, LCG_C);
    // 33-bit compare so cycles = FFFFFFFF cannot wrap to an early finish.
    assign last_vec  = ({1'b0, vec_count} + 33'd1) == ({1'b0, cycles_q} + 33'd1);
    assign misr_en   = !abort_ok && (((state == COMMIT) && (vec_count != 32'd0)) ||
                                     ((state == DRAIN) && (k == K_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nxt = RESET;
            RESET:      if (rst_cnt == R_LAST) state_nxt = FILL;
            FILL:       if (k == K_LAST) state_nxt = COMMIT;
            COMMIT:     state_nxt = last_vec ? DRAIN : FILL;
            DRAIN:      if (k == K_LAST) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (abort_ok) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            rst_cnt   <= '0;
            lcg_s     <= '0;
            cycles_q  <= '0;
            vec_count <= '0;
            in_flat   <= '0;
        end else if (start_ok) begin
            lcg_s     <= seed;
            cycles_q  <= cycles;
            vec_count <= '0;
            in_flat   <= '0;
            rst_cnt   <= '0;
            k         <= '0;
        end else if (abort_ok) begin
            in_flat <= '0;
        end else begin
            case (state)
                RESET: begin
                    rst_cnt <= rst_cnt + 1'b1;
                    k       <= '0;
                end
                FILL: begin
                    lcg_s <= lcg_nxt;
                    k     <= (k == K_LAST) ? '0 : k + 1'b1;
                end
                COMMIT: begin
                    in_flat   <= shadow;
                    vec_count <= vec_count + 32'd1;
                    k         <= '0;
                end
                DRAIN:   k <= k + 1'b1;
                default: ;
            endcase
        end
    end

    // The top word is narrower, so it keeps only the low bits of its LCG step.
    for (genvar w = 0; w < NWORDS; w++) begin : g_word
        localparam int LO = 32 * w;
        localparam int WW = (IN_W - LO < 32) ? (IN_W - LO) : 32;
        logic [WW-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (state == FILL && k == KW'(w) && !abort_ok) begin
                word_q <= lcg_nxt[WW-1:0];
            end
        end

        assign shadow[LO +: WW] = word_q;
    end

    sig_misr32 #(.OUT_W(OUT_W)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_ok),
        .en    (misr_en),
        .data  (out_flat),
        .sig   (signature)
    );

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Self-checking bench for fuzz_stim_sequencer: vector and signature
// scoreboard, timing of reset/fill/commit/drain, abort and async reset.
module tb_fuzz_stim_sequencer;
    import fuzz_seq_pkg::*;

    localparam int IN_W       = 265;
    localparam int OUT_W      = 330;
    localparam int RST_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst_n, start, abort;
    logic [31:0]      seed, cycles;
    logic             dut_rst_n, busy, done;
    logic [IN_W-1:0]  in_flat;
    logic [OUT_W-1:0] out_flat;
    logic [31:0]      vec_count, signature;
    state_t           dbg_state;

    logic [IN_W-1:0] exp_q[$];
    logic [31:0]     sig_q[$];
    int              checks = 0;
    int              errors = 0;
    int              pat_mode = 0;
    int              flip_n = 0;

    always #5 clk = ~clk;

    fuzz_stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .RST_CYCLES(RST_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .seed      (seed),
        .cycles    (cycles),
        .dut_rst_n (dut_rst_n),
        .in_flat   (in_flat),
        .out_flat  (out_flat),
        .busy      (busy),
        .done      (done),
        .vec_count (vec_count),
        .signature (signature),
        .dbg_state (dbg_state)
    );

    function automatic logic [31:0] lcg(input logic [31:0] s);
        return s * 32'h41C64E6D + 32'h00003039;
    endfunction

    // Response pattern keyed on vec_count; optional single-bit flip at flip.
    function automatic logic [OUT_W-1:0] out_pat(input logic [31:0] n, input int mode, input int flip);
        logic [351:0] t;
        t = '0;
        if (mode != 0) begin
            for (int i = 0; i < 11; i++) t[32*i +: 32] = (n * 32'h9E3779B9) ^ (32'(i) * 32'h01000193);
        end
        if (flip != 0 && n == 32'(flip)) t[300] = ~t[300];
        return t[OUT_W-1:0];
    endfunction

    // Signature after absorbing responses for vec_count = 1..nabs.
    function automatic logic [31:0] sig_model(input int nabs, input int mode, input int flip);
        logic [31:0]  sig, fold;
        logic [351:0] pad;
        sig = 32'hFFFFFFFF;
        for (int n = 1; n <= nabs; n++) begin
            pad            = '0;
            pad[OUT_W-1:0] = out_pat(32'(n), mode, flip);
            fold           = '0;
            for (int i = 0; i < 11; i++) fold = fold ^ pad[32*i +: 32];
            sig = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ fold;
        end
        return sig;
    endfunction

    assign out_flat = out_pat(vec_count, pat_mode, flip_n);

    task automatic check(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One run with scoreboard; abort_vc>0 aborts in the FILL after that many
    // commits, busy_vc>0 pulses start while busy after that many commits.
    task automatic run(input logic [31:0] sd, input logic [31:0] cyc, input int mode,
                       input int flip, input int abort_vc, input int busy_vc);
        logic [287:0] v;
        logic [31:0]  s, last_vc;
        int           prev_n, rst_low, fill_cnt;
        bit           pulsed, finished;
        pat_mode = mode;
        flip_n   = flip;
        s = sd;
        for (int x = 0; x <= int'(cyc); x++) begin
            for (int j = 0; j < 9; j++) begin
                s = lcg(s);
                v[32*j +: 32] = s;
            end
            exp_q.push_back(v[IN_W-1:0]);
        end
        if (abort_vc == 0) sig_q.push_back(sig_model(int'(cyc) + 1, mode, flip));
        @(negedge clk);
        seed = sd; cycles = cyc; start = 1'b1;
        last_vc = 0; prev_n = 0; rst_low = 0; fill_cnt = 0; pulsed = 0; finished = 0;
        for (int n = 1; n <= 20 * int'(cyc) + 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (!dut_rst_n && busy) rst_low++;
            if (vec_count != last_vc) begin
                check("vec_step", vec_count, last_vc + 32'd1);
                if (exp_q.size() == 0) check("exp_underflow", 0, 1);
                else check("in_flat", in_flat, exp_q.pop_front());
                check("period", n - prev_n, (prev_n == 0) ? 13 : 10);
                prev_n  = n;
                last_vc = vec_count;
            end
            if (busy_vc != 0 && !pulsed && vec_count == 32'(busy_vc) && dbg_state == FILL) begin
                start  = 1'b1;
                seed   = $urandom;
                cycles = 0;
                pulsed = 1;
            end
            if (abort_vc != 0 && vec_count == 32'(abort_vc) && dbg_state == FILL) begin
                fill_cnt++;
                if (fill_cnt == 3) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_state", dbg_state, IDLE);
                    check("abort_dut_rst_n", dut_rst_n, 0);
                    check("abort_in_flat", in_flat, 0);
                    check("abort_busy", busy, 0);
                    check("abort_vec_hold", vec_count, abort_vc);
                    check("abort_sig_hold", signature, sig_model(abort_vc - 1, mode, flip));
                    exp_q.delete();
                    finished = 1;
                    break;
                end
            end
            if (done) begin
                check("done_time", n, 22 + 10 * cyc);
                check("rst_low", rst_low, RST_CYCLES);
                check("vec_final", vec_count, cyc + 32'd1);
                check("signature", signature, sig_q.pop_front());
                check("q_drained", exp_q.size(), 0);
                finished = 1;
                break;
            end
        end
        if (!finished) begin
            check("timeout", 0, 1);
            exp_q.delete();
            sig_q.delete();
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; cycles = '0;
        repeat (3) @(negedge clk);
        check("rst_state", dbg_state, IDLE);
        check("rst_dut_rst_n", dut_rst_n, 0);
        check("rst_in_flat", in_flat, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec", vec_count, 0);
        check("rst_sig", signature, 32'hFFFFFFFF);
        rst_n = 1'b1;
        @(negedge clk);

        // Single vector from seed 0: glibc-style LCG words and one absorb.
        run(32'd0, 32'd0, 1, 0, 0, 0);
        check("t1_word0", in_flat[31:0], 32'h00003039);
        check("t1_word1", in_flat[63:32], 32'hD3DC167E);
        check("t1_done", done, 1);

        // Zero responses, then the same run repeated straight from DONE.
        run(32'd311570307, 32'd5, 0, 0, 0, 0);
        run(32'd311570307, 32'd5, 0, 0, 0, 0);

        // Start ignored while busy, abort mid-run, then a clean restart.
        run(32'hCAFE_0001, 32'd10, 1, 0, 2, 1);
        run(32'hCAFE_0001, 32'd3, 1, 0, 0, 0);

        // Asynchronous reset landing in a COMMIT cycle.
        @(negedge clk);
        seed = 32'h1234_5678; cycles = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (dbg_state == COMMIT && vec_count >= 32'd1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) check("t5_timeout", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_state", dbg_state, IDLE);
        check("t5_dut_rst_n", dut_rst_n, 0);
        check("t5_in_flat", in_flat, 0);
        check("t5_busy", busy, 0);
        check("t5_vec", vec_count, 0);
        check("t5_sig", signature, 32'hFFFFFFFF);
        @(negedge clk);
        rst_n = 1'b1;

        // Patterned responses, then the same run with one flipped bit.
        run(32'h0BAD_F00D, 32'd4, 1, 0, 0, 0);
        run(32'h0BAD_F00D, 32'd4, 1, 3, 0, 0);
        check("sig_diff", signature != sig_model(5, 1, 0), 1);

        for (int r = 0; r < 2; r++) run($urandom, 32'($urandom_range(0, 4)), 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
